// File: rtl/alu_seq_pkg.sv
// Shared types for the nibble-serial ALU sequencer: opcodes, FSM states, slice width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_ADC = 3'd2,
    OP_SBC = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_slice.sv
// Purely combinational 4-bit ALU slice used once per cycle by the sequencer.
// Latency: 0 cycles (combinational).
// Backpressure: none.
// Ports: a/b nibble operands, cin carry-in, op opcode; y result nibble,
//        cout carry-out of bit 3, c3 carry into bit 3 (for signed overflow).
//        OP_CMP here means "pass A through" (the controller remaps CMP to SUB
//        when the compare feature is enabled).
module alu_slice
  import alu_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  op_e                op,
  output logic [SLICE_W-1:0] y,
  output logic               cout,
  output logic               c3
);

  logic [SLICE_W-1:0] w_b_eff;
  logic [3:0]         w_lo;  // bits 2:0 sum, bit 3 = carry into bit 3
  logic [1:0]         w_hi;  // bit 3 sum and carry-out

  always_comb begin
    w_b_eff = (op == OP_SUB || op == OP_SBC) ? ~b : b;
    w_lo    = {1'b0, a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, cin};
    w_hi    = {1'b0, a[3]} + {1'b0, w_b_eff[3]} + {1'b0, w_lo[3]};
    y       = a;
    cout    = 1'b0;
    c3      = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        y    = {w_hi[0], w_lo[2:0]};
        cout = w_hi[1];
        c3   = w_lo[3];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Nibble-serial WIDTH-bit ALU sequencer: LSB nibble first, carry chained between passes.
// Latency: res_valid rises NSLICE cycles after command acceptance; flag_update pulses once then.
// Backpressure: result held in DONE until res_ready; cmd_ready low from acceptance until consumed.
// Ports: clk, reset (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b command
//        channel; carry_flag stored carry (sampled on accept); res_valid/res_ready/res_data
//        result channel; flag_update strobe with zero/negative/carry/overflow_out values.
// Build option: define ALU_SEQ_CMP_EN to make opcode 7 a compare (SUB flags, no result);
//        otherwise opcode 7 is a NOP returning operand A without touching the flags.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             carry_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             flag_update,
  output logic             zero_out,
  output logic             negative_out,
  output logic             carry_out,
  output logic             overflow_out
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

`ifdef ALU_SEQ_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  state_e             r_state;
  logic [CW-1:0]      r_cnt;
  op_e                r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_carry;

  op_e                w_cmd_op;
  op_e                w_slice_op;
  logic               w_cin0;
  int                 w_base;
  logic [SLICE_W-1:0] w_y;
  logic               w_cout;
  logic               w_c3;
  logic [WIDTH-1:0]   w_res_full;
  logic               w_last;
  logic               w_is_logic;
  logic               w_is_cmp;
  logic               w_is_nop;

  always_comb begin
    w_cmd_op   = op_e'(cmd_op);
    // Compare runs through the slice as a plain subtract.
    w_slice_op = (r_op == OP_CMP && CMP_EN) ? OP_SUB : r_op;
    w_is_logic = (r_op == OP_AND) || (r_op == OP_OR) || (r_op == OP_XOR);
    w_is_cmp   = (r_op == OP_CMP) && CMP_EN;
    w_is_nop   = (r_op == OP_CMP) && !CMP_EN;
    w_base     = int'(r_cnt) * SLICE_W;
    w_last     = (r_cnt == CW'(NSLICE - 1));
    case (w_cmd_op)
      OP_SUB, OP_CMP: w_cin0 = 1'b1;
      OP_ADC, OP_SBC: w_cin0 = carry_flag;
      default:        w_cin0 = 1'b0;
    endcase
    // Accumulated result with the current slice merged in, so flags on the
    // last pass see the complete word.
    w_res_full                   = r_acc;
    w_res_full[w_base +: SLICE_W] = w_y;
  end

  alu_slice u_slice (
    .a    (r_a[w_base +: SLICE_W]),
    .b    (r_b[w_base +: SLICE_W]),
    .cin  (r_carry),
    .op   (w_slice_op),
    .y    (w_y),
    .cout (w_cout),
    .c3   (w_c3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_op         <= OP_ADD;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      cmd_ready    <= 1'b1;
      res_valid    <= 1'b0;
      res_data     <= '0;
      flag_update  <= 1'b0;
      zero_out     <= 1'b0;
      negative_out <= 1'b0;
      carry_out    <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          flag_update <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            r_op      <= w_cmd_op;
            r_a       <= cmd_a;
            r_b       <= cmd_b;
            r_carry   <= w_cin0;
            r_acc     <= '0;
            r_cnt     <= '0;
            cmd_ready <= 1'b0;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_acc   <= w_res_full;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= ST_DONE;
            if (!w_is_nop) begin
              flag_update  <= 1'b1;
              zero_out     <= (w_res_full == '0);
              negative_out <= w_res_full[WIDTH-1];
              carry_out    <= w_is_logic ? 1'b0 : w_cout;
              // Signed overflow == carry into MSB differs from carry out of MSB.
              overflow_out <= w_is_logic ? 1'b0 : (w_cout ^ w_c3);
            end
            if (!w_is_cmp) begin
              res_data  <= w_res_full;
              res_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          flag_update <= 1'b0;
          if (w_is_cmp || (res_valid && res_ready)) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl (WIDTH=8) using directed vectors.
// Latency: expects res_valid/flag_update two cycles after command acceptance.
// Backpressure: exercises a held result with res_ready low for several cycles.
module tb_alu_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         carry_flag = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         flag_update;
  logic         zero_out, negative_out, carry_out, overflow_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] q_res[$];
  logic [3:0]   q_flag[$];  // {Z,N,C,V}

  always #5 clk = ~clk;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .carry_flag   (carry_flag),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .flag_update  (flag_update),
    .zero_out     (zero_out),
    .negative_out (negative_out),
    .carry_out    (carry_out),
    .overflow_out (overflow_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pops expectations whenever the DUT presents a flag strobe or a result.
  always @(negedge clk) begin
    if (!reset) begin
      if (flag_update) begin
        if (q_flag.size() == 0) chk("spurious_flag_update", {31'd0, flag_update}, 32'd0);
        else chk("flags_ZNCV", {28'd0, zero_out, negative_out, carry_out, overflow_out},
                 {28'd0, q_flag.pop_front()});
      end
      if (res_valid && res_ready) begin
        if (q_res.size() == 0) chk("spurious_res_valid", {31'd0, res_valid}, 32'd0);
        else chk("res_data", {24'd0, res_data}, {24'd0, q_res.pop_front()});
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 30 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) chk({name, "_idle_timeout"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  // Drives one command through the acceptance edge; returns #1 after it.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cf);
    wait_idle("send");
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_a      = a;
    cmd_b      = b;
    carry_flag = cf;
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    cmd_op     = 3'd0;
    carry_flag = 1'b0;
  endtask

  task automatic run_cmd(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cf,
                         input logic has_res, input logic [W-1:0] exp_res,
                         input logic has_flag, input logic [3:0] exp_flags);
    if (has_res)  q_res.push_back(exp_res);
    if (has_flag) q_flag.push_back(exp_flags);
    send(op, a, b, cf);
    chk({name, "_busy_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
    chk({name, "_res_valid_early1"}, {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_res_valid_early2"}, {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_res_valid_lat"}, {31'd0, res_valid}, {31'd0, has_res});
    chk({name, "_flag_update_lat"}, {31'd0, flag_update}, {31'd0, has_flag});
    @(posedge clk); #1;
    chk({name, "_flag_update_once"}, {31'd0, flag_update}, 32'd0);
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data", {24'd0, res_data}, 32'd0);
    chk("rst_flag_update", {31'd0, flag_update}, 32'd0);
    chk("rst_flags", {28'd0, zero_out, negative_out, carry_out, overflow_out}, 32'd0);

    //      name     op    A      B      cf    res   data   flg   ZNCV
    run_cmd("add7f", 3'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 4'b0101);
    run_cmd("sub0",  3'd1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 4'b0100);
    run_cmd("sub5",  3'd1, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 4'b1010);
    run_cmd("adc",   3'd2, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 4'b1010);
    run_cmd("sbc",   3'd3, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0E, 1'b1, 4'b0010);
    run_cmd("or",    3'd5, 8'hA0, 8'h05, 1'b1, 1'b1, 8'hA5, 1'b1, 4'b0100);
    run_cmd("xor",   3'd6, 8'h5A, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b1, 4'b1000);

    // AND under backpressure, with a stray command pulse while busy.
    res_ready = 1'b0;
    q_res.push_back(8'h30);
    q_flag.push_back(4'b0000);
    send(3'd4, 8'hF0, 8'h3C, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("and_res_valid", {31'd0, res_valid}, 32'd1);
    chk("and_flag_update", {31'd0, flag_update}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i == 2);
      cmd_op    = 3'd0;
      cmd_a     = 8'h11;
      cmd_b     = 8'h11;
      @(posedge clk); #1;
      chk("and_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("and_hold_data", {24'd0, res_data}, 32'h30);
      chk("and_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("and_hold_no_flag", {31'd0, flag_update}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("and_consumed_valid", {31'd0, res_valid}, 32'd0);
    chk("and_consumed_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset during the second EXEC cycle aborts the command.
    send(3'd0, 8'h44, 8'h44, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_flag_update", {31'd0, flag_update}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_quiet", {30'd0, res_valid, flag_update}, 32'd0);
    end
    run_cmd("after_abort", 3'd0, 8'h11, 8'h22, 1'b0, 1'b1, 8'h33, 1'b1, 4'b0000);

`ifdef ALU_SEQ_CMP_EN
    run_cmd("cmp", 3'd7, 8'h12, 8'h12, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1010);
    chk("cmp_res_data_kept", {24'd0, res_data}, 32'h33);
`else
    run_cmd("nop", 3'd7, 8'h12, 8'h12, 1'b0, 1'b1, 8'h12, 1'b0, 4'b0000);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("res_queue_drained", q_res.size(), 32'd0);
    chk("flag_queue_drained", q_flag.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Multi-cycle sequencer that runs WIDTH-bit arithmetic and logic commands over a single 4-bit ALU slice, one nibble per cycle, LSB first, chaining carry between passes. It accepts commands on a valid/ready interface and returns results on a valid/ready interface. On completion it drives the flag register's update strobe and flag inputs, computed over the full operand width. It reads back the stored carry flag for ADC/SBC.

Parameters:
WIDTH, 8, operand/result width; must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 CMP/NOP
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
carry_flag  in  1  stored carry from the flag register; sampled at command acceptance
res_valid  out  1  result available
res_ready  in  1  consumer takes the result
res_data  out  WIDTH  result
flag_update  out  1  one-cycle strobe to the flag register update input
zero_out, negative_out, carry_out, overflow_out  out  1 each  flag values for the flag register

Behaviour:
- States: IDLE, EXEC, DONE.
- Reset: state IDLE. cmd_ready=1, res_valid=0, res_data=0, flag_update=0, all flag outputs=0, slice counter=0. Reset in any state, including mid-EXEC, aborts the command with no flag_update.
- IDLE: cmd_ready=1.
  - cmd_valid && cmd_ready at an edge latches op, A, B and carry_flag. Next state EXEC, counter=0.
- EXEC: cmd_ready=0. Each cycle computes slice[counter] from A/B nibble [4k+3:4k] and the carry chain, writes the result nibble, and increments the counter. The edge with counter==NSLICE-1 moves to DONE.
  - Latency: res_valid is high NSLICE cycles after the accepting edge (2 for WIDTH=8).
- Carry-in to slice 0:
  - ADD: 0; SUB: 1 (B inverted); ADC: latched carry_flag; SBC: latched carry_flag (B inverted); CMP: 1 (B inverted).
  - Slice k>0 takes carry-out of slice k-1.
- Logical ops (AND/OR/XOR): bitwise per nibble; carry_out=0, overflow_out=0.
- Flags, computed over the full WIDTH:
  - zero = (result==0); negative = result[WIDTH-1].
  - carry = carry-out of the top slice; for subtraction this is NOT borrow.
  - overflow = signed overflow: operand signs equal and result sign differs, with B taken post-inversion.
- DONE: res_valid=1 and res_data stable until res_valid && res_ready, then IDLE. cmd_ready stays 0 throughout DONE.
  - flag_update=1 only in the first DONE cycle, never repeated under backpressure. Flag outputs hold their values through DONE.
- A new command is not accepted in the same cycle the result is consumed; the earliest acceptance is the following cycle.
- cmd_op changes while not ready are ignored.

Optional Feature:
ALU_SEQ_CMP_EN.
- Defined: opcode 7 = CMP. Runs as SUB, asserts flag_update with SUB flags, and skips result delivery: DONE lasts exactly one cycle with res_valid=0, then IDLE. res_data keeps its previous value.
- Undefined: opcode 7 = NOP. Takes NSLICE EXEC cycles, returns res_data=A with res_valid handshake, and never asserts flag_update.

Decomposition:
- Package alu_seq_pkg: opcode enum (ADD..CMP), state enum (IDLE/EXEC/DONE), constant SLICE_W=4.
- Sub-module alu_slice: purely combinational 4-bit op. Inputs a, b, cin, op. Outputs y, cout, plus c3 (carry into bit 3) used for top-slice overflow.
- Controller owns the FSM, counter, operand registers and flag logic.

Test Plan:
- WIDTH=8. ADD 0x7F+0x01, res_ready=1 -> res_data=0x80, Z0 N1 C0 V1. res_valid exactly 2 cycles after acceptance. flag_update high 1 cycle.
- SUB 0x00-0x01 -> 0xFF, Z0 N1 C0 V0. Then SUB 0x05-0x05 -> 0x00, Z1 N0 C1 V0.
- ADC 0xFF+0x00 with carry_flag=1 -> 0x00, Z1 C1. SBC 0x10-0x01 with carry_flag=0 -> 0x0E, C1.
- AND 0xF0&0x3C, res_ready held low 5 cycles -> res_data=0x30 held stable, cmd_ready=0, single flag_update, C0 V0. cmd_valid pulsed during wait is ignored.
- Reset asserted on second EXEC cycle of ADD -> next cycle IDLE, cmd_ready=1, res_valid=0, flag_update never seen. Next command executes correctly.
- Opcode 7, A=0x12, B=0x12: with ALU_SEQ_CMP_EN -> flag_update with Z1 C1, no res_valid. Without it -> res_data=0x12, no flag_update.
